// File: rtl/proc_out_uart.sv
// Serial console adapter: whenever the processor's out0 value changes, send it
// over an 8N1 UART line as eight uppercase hex digits followed by CR LF.
module proc_out_uart #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] out_data,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         last_sent_q, last_sent_d;
    logic [31:0]         snap_q, snap_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [3:0]          char_q, char_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          cur_char_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] res;
        if (nib < 4'd10) begin
            res = 8'h30 + {4'h0, nib};
        end else begin
            res = 8'h37 + {4'h0, nib};
        end
        return res;
    endfunction

    // Chars 0..7 are nibbles of the snapshot MSB first, then CR, LF.
    function automatic logic [7:0] char_at(input logic [31:0] snap, input logic [3:0] idx);
        logic [7:0] res;
        logic [2:0] pos;
        pos = 3'd7 - idx[2:0];
        case (idx)
            4'd8:    res = 8'h0D;
            4'd9:    res = 8'h0A;
            default: res = hex_ascii(snap[{pos, 2'b00} +: 4]);
        endcase
        return res;
    endfunction

    assign cur_char_s = char_at(snap_q, char_q);

    // Next-state and next-output logic for the transmit FSM.
    always_comb begin
        state_d      = state_q;
        last_sent_d  = last_sent_q;
        snap_d       = snap_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        char_d       = char_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (out_data != last_sent_q) begin
                    snap_d      = out_data;
                    last_sent_d = out_data;
                    char_d      = 4'd0;
                    bit_d       = 3'd0;
                    baud_d      = '0;
                    state_d     = START;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = cur_char_s[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_char_s[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (char_q == 4'd9) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        char_d  = char_q + 4'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                    // Raise the pulse so it is visible during the last stop cycle.
                    frame_done_d = (char_q == 4'd9) && (baud_q == BAUD_PRE);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_sent_q  <= 32'h0000_0000;
            snap_q       <= 32'h0000_0000;
            baud_q       <= '0;
            bit_q        <= 3'd0;
            char_q       <= 4'd0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_sent_q  <= last_sent_d;
            snap_q       <= snap_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            char_q       <= char_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_proc_out_uart.sv
// Self-checking bench for proc_out_uart: a UART decoder pops expected characters
// from a scoreboard queue; frame timing and corner cases are checked alongside.
module tb_proc_out_uart;

    localparam int CPB = 4;
    localparam int FRAME_CYC = 100 * CPB;

    logic        clk;
    logic        rst;
    logic [31:0] out_data;
    logic        tx;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int exp_frames = 0;
    int fd_cnt = 0;

    // Decoder / timing monitor state
    logic       m_active = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_byte = 8'h00;
    int         busy_run = 0;

    typedef struct {
        logic [31:0] val;
        logic        send;
        int          hold;
    } vec_t;

    proc_out_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .out_data   (out_data),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] exp_hex(input logic [3:0] n);
        logic [7:0] tblc[16];
        tblc = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                 8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return tblc[n];
    endfunction

    task automatic push_frame(input logic [31:0] v);
        for (int i = 7; i >= 0; i--) exp_q.push_back(exp_hex(v[i*4 +: 4]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        exp_frames++;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < FRAME_CYC + 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_timeout"}, !busy, {31'h0, busy}, 32'h0);
    endtask

    // UART decoder and busy/frame_done timing monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            busy_run = 0;
            exp_q.delete();
        end else begin
            if (!m_active) begin
                if (tx === 1'b0) begin
                    m_active = 1'b1;
                    m_cnt = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt % CPB == CPB / 2) begin
                    if (m_cnt / CPB == 0) begin
                        check("start_bit", tx === 1'b0, {31'h0, tx}, 32'h0);
                    end else if (m_cnt / CPB <= 8) begin
                        m_byte[m_cnt / CPB - 1] = tx;
                    end else begin
                        check("stop_bit", tx === 1'b1, {31'h0, tx}, 32'h1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_char", 1'b0, {24'h0, m_byte}, 32'h0);
                        end else begin
                            logic [7:0] e;
                            e = exp_q.pop_front();
                            check("char", m_byte === e, {24'h0, m_byte}, {24'h0, e});
                        end
                        m_active = 1'b0;
                    end
                end
            end
            if (busy === 1'b1) busy_run++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                check("frame_done_pos", busy_run == FRAME_CYC, busy_run, FRAME_CYC);
            end
            if (busy !== 1'b1 && busy_run != 0) begin
                check("busy_len", busy_run == FRAME_CYC, busy_run, FRAME_CYC);
                busy_run = 0;
            end
        end
    end

    initial begin
        vec_t tbl[6];
        int viol;
        int gap;

        tbl[0] = '{val: 32'h0000_00A5, send: 1'b1, hold: 0};
        tbl[1] = '{val: 32'hDEAD_BEEF, send: 1'b1, hold: 0};
        tbl[2] = '{val: 32'h0000_0007, send: 1'b1, hold: 0};
        tbl[3] = '{val: 32'h0000_0007, send: 1'b0, hold: 600};
        tbl[4] = '{val: 32'h0000_0000, send: 1'b1, hold: 0};
        tbl[5] = '{val: 32'h9ABC_DEF0, send: 1'b1, hold: 0};

        // Reset held high, then idle with zero input
        rst = 1'b1;
        out_data = 32'h1234_5678;
        viol = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) viol++;
        end
        rst = 1'b0;
        out_data = 32'h0000_0000;
        check("reset_state", tx === 1'b1 && busy === 1'b0 && frame_done === 1'b0,
              {29'h0, tx, busy, frame_done}, 32'h4);
        repeat (50) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) viol++;
        end
        check("reset_idle", viol == 0, viol, 0);

        // Table-driven value changes
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            out_data = tbl[i].val;
            if (tbl[i].send) push_frame(tbl[i].val);
            @(posedge clk); #1;
            if (tbl[i].send) begin
                check("start_latency", tx === 1'b0 && busy === 1'b1, {30'h0, tx, busy}, 32'h1);
                wait_idle("frame");
            end else begin
                viol = 0;
                for (int c = 0; c < tbl[i].hold; c++) begin
                    if (busy !== 1'b0 || tx !== 1'b1) viol++;
                    @(posedge clk); #1;
                end
                check("no_retransmit", viol == 0, viol, 0);
            end
        end

        // Changes during a frame: only the value present after the frame is sent
        @(posedge clk); #1;
        out_data = 32'h0000_0001;
        push_frame(32'h0000_0001);
        push_frame(32'h0000_0003);
        repeat (50) @(posedge clk);
        #1 out_data = 32'h0000_0002;
        repeat (50) @(posedge clk);
        #1 out_data = 32'h0000_0003;
        wait_idle("chg_frame1");
        gap = 0;
        while (!busy && gap < 10) begin
            @(posedge clk); #1;
            gap++;
        end
        check("busy_gap", gap == 1, gap, 1);
        wait_idle("chg_frame2");
        viol = 0;
        repeat (500) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) viol++;
        end
        check("no_third_frame", viol == 0, viol, 0);

        // Reset in the middle of a frame
        @(posedge clk); #1;
        out_data = 32'hCAFE_F00D;
        push_frame(32'hCAFE_F00D);
        repeat (149) @(posedge clk);
        #1 rst = 1'b1;
        exp_frames--;
        @(posedge clk); #1;
        check("midreset_lines", tx === 1'b1 && busy === 1'b0, {30'h0, tx, busy}, 32'h2);
        rst = 1'b0;
        push_frame(32'hCAFE_F00D);
        @(posedge clk); #1;
        check("restart_after_reset", tx === 1'b0 && busy === 1'b1, {30'h0, tx, busy}, 32'h1);
        wait_idle("restart_frame");
        repeat (5) @(posedge clk);
        #1;

        check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        check("frame_done_count", fd_cnt == exp_frames, fd_cnt, exp_frames);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_out_uart.md
# proc_out_uart

Serial console adapter downstream of the processor's `out0` I/O port. Watches the 32-bit value the program writes to `out0`. Whenever that value differs from the last value transmitted, it sends the value over a UART TX line as eight uppercase ASCII hex digits followed by CR LF. This lets the FPGA build print processor results to a host terminal without software support.

## Interface

Parameters:

- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud). Legal range is ≥ 2.

Ports:

- `clk`  input  1: clock.
- `rst`  input  1: synchronous, active-high reset.
- `out_data`  input  32: value driven by the processor's `out0` port. Sampled on every rising edge.
- `tx`  output  1: UART transmit line, 8N1 format, idle high.
- `busy`  output  1: high while a frame is in progress.
- `frame_done`  output  1: one-cycle pulse on the last cycle of a frame's final stop bit.

## Operation

- Registers:
  - `last_sent[31:0]`, reset 0.
  - `snap[31:0]`, the value being sent.
  - Baud counter: 0..CLKS_PER_BIT-1.
  - Bit index: 0..7.
  - Char index: 0..9.
- FSM states are IDLE, START, DATA and STOP. Reset enters IDLE.
- IDLE:
  - If `out_data != last_sent` at a rising edge, then at that edge: `snap <= out_data`, `last_sent <= out_data`, char index 0, baud counter 0, go to START.
  - Otherwise remain in IDLE.
- Character stream for one frame, in order:
  - Chars 0–7 are the hex digits of `snap`, most significant nibble first. Nibbles 0–9 map to 0x30–0x39; nibbles A–F map to 0x41–0x46 (uppercase).
  - Char 8 is 0x0D (CR).
  - Char 9 is 0x0A (LF).
- Each character is sent as one start bit (0), then 8 data bits LSB first, then one stop bit (1).
- START: `tx=0` for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: `tx` = bit[bit index] of the current character for CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: `tx=1` for CLKS_PER_BIT cycles. At the end of the stop bit:
  - If char index < 9: increment the char index and go to START. There is no idle gap between characters.
  - If char index = 9: assert `frame_done` on the final stop cycle and go to IDLE.
- Changes to `out_data` during a frame are ignored. `snap` is frozen for the whole frame.
  - On return to IDLE, the comparison with `last_sent` is made again on the next edge. Only the value present at that edge is sent; intermediate values are dropped.
- `tx` and `busy` are driven from registers, never combinationally from `out_data`.
- A value equal to `last_sent` is never retransmitted. A value of 0 after reset is not sent, because `last_sent` resets to 0.

## Timing

- Reset values: `tx=1`, `busy=0`, `frame_done=0`, FSM=IDLE, `last_sent=0`, all counters 0.
- Latency: if `out_data != last_sent` at edge E, then `tx` falls and `busy` rises at edge E. Both are visible in the cycle after E.
- Each bit lasts exactly CLKS_PER_BIT cycles.
  - One character = 10 × CLKS_PER_BIT cycles.
  - One frame = 100 × CLKS_PER_BIT cycles.
- `busy` stays high for exactly 100 × CLKS_PER_BIT consecutive cycles per frame. It goes low at the edge that ends the frame, in the same cycle that `frame_done` drops.
- Back-to-back frames:
  - If `out_data != last_sent` at the edge after the frame ends, the next start bit begins there.
  - The line sits idle-high for at least one cycle between frames.
  - `busy` is low for exactly one cycle between frames.
- Reset mid-frame:
  - At the reset edge, `tx=1` and `busy=0`.
  - The partial character is abandoned and `last_sent=0`.
  - After reset deasserts, a nonzero `out_data` starts a fresh frame.
- Reset held high: no transmission regardless of `out_data`.

## Test plan

All scenarios use CLKS_PER_BIT=4.

- **Reset:** assert `rst` for 2 cycles with `out_data`=0x12345678, then deassert with `out_data`=0 for 50 cycles → `tx`=1, `busy`=0 and `frame_done`=0 throughout.
- **Basic frame:** set `out_data`=0x000000A5 → decoded stream is 0x30 ×6, 0x41, 0x35, 0x0D, 0x0A.
  - `busy` is high for exactly 400 cycles.
  - `frame_done` pulses once, on cycle 400.
  - `tx` is low in the cycle after the change.
- **Uppercase and ordering:** set `out_data`=0xDEADBEEF → decoded stream is "DEADBEEF\r\n" (0x44, 0x45, 0x41, 0x44, 0x42, 0x45, 0x45, 0x46, 0x0D, 0x0A). Every bit is sampled mid-period and matches.
- **Change during frame:** set 0x00000001, then at cycle 50 set 0x00000002, and at cycle 100 set 0x00000003 → frame 1 is "00000001\r\n".
  - `busy` is low for one cycle.
  - Frame 2 is "00000003\r\n"; 0x00000002 is never sent.
  - No third frame follows.
- **No retransmit:** hold 0x00000007 for 1000 cycles → exactly one frame.
  - Writing 0x00000007 again has no effect.
  - Changing to 0 sends "00000000\r\n".
- **Reset mid-frame:** set 0xCAFEF00D and pulse `rst` at cycle 150 → `tx`=1 and `busy`=0 in the cycle after the reset edge.
  - With `out_data` still 0xCAFEF00D after reset deasserts, a complete new frame "CAFEF00D\r\n" is sent starting at the first edge after reset deasserts.
